tea_dec_asmd: RTL

Iterative TEA decryption engine, the inverse partner of the existing TEA encryption ASMD core. It sits behind the same start/rdy/valid handshake as the encryption core and drops into the same x8 array wrappers. The engine takes one 64-bit ciphertext block and a 128-bit key, runs the 32 TEA rounds in reverse, and presents the 64-bit plaintext with a one-cycle `valid` pulse.

---
 rtl/tea_pkg.sv | 19 +
 rtl/tea_dec_round.sv | 30 +++
 rtl/tea_dec_asmd.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tea_pkg.sv
// Shared TEA constants and the ASMD state type. The encryption and decryption
// cores both import this package.
//   TEA_DELTA    : key-schedule constant added (encrypt) or removed (decrypt) each round
//   TEA_SUM_INIT : TEA_DELTA * 32, the value of sum after a full 32-round encryption
//   TEA_ROUNDS   : nominal round count
//   tea_state_t  : idle / run / done controller states
package tea_pkg;

  localparam logic [31:0] TEA_DELTA    = 32'h9E37_79B9;
  localparam logic [31:0] TEA_SUM_INIT = 32'hC6EF_3720;
  localparam int unsigned TEA_ROUNDS   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } tea_state_t;

endpackage

// File: rtl/tea_dec_round.sv
// One inverse TEA round, purely combinational.
//   v0_i, v1_i  : current half-blocks
//   sum_i       : running key-schedule sum for this round
//   k0_i..k3_i  : key words
//   v0_o, v1_o  : half-blocks after undoing one encryption round
//   sum_o       : sum for the following (earlier) round
module tea_dec_round
  import tea_pkg::*;
(
  input  logic [31:0] v0_i,
  input  logic [31:0] v1_i,
  input  logic [31:0] sum_i,
  input  logic [31:0] k0_i,
  input  logic [31:0] k1_i,
  input  logic [31:0] k2_i,
  input  logic [31:0] k3_i,
  output logic [31:0] v0_o,
  output logic [31:0] v1_o,
  output logic [31:0] sum_o
);

  // Encryption updates v0 then v1, so decryption undoes v1 first and feeds the
  // recovered v1 into the v0 step.
  always_comb begin
    v1_o  = v1_i - (((v0_i << 4) + k2_i) ^ (v0_i + sum_i) ^ ((v0_i >> 5) + k3_i));
    v0_o  = v0_i - (((v1_o << 4) + k0_i) ^ (v1_o + sum_i) ^ ((v1_o >> 5) + k1_i));
    sum_o = sum_i - TEA_DELTA;
  end

endmodule

// File: rtl/tea_dec_asmd.sv
// Iterative TEA decryption engine with start/rdy/valid handshake.
// Build option: define TEA_DEC_UNROLL2_EN to run two chained rounds per cycle
// (half the latency, bit-identical results).
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   ena    : clock enable; all state frozen while low
//   start  : decrypt request, taken only when ena && rdy
//   data   : ciphertext {v0, v1}
//   key    : {k0, k1, k2, k3}
//   result : plaintext {v0, v1}, held until the next accepted start
//   valid  : high while in the done state (one enabled cycle)
//   rdy    : engine idle
// ROUNDS must be a power of two, at least 2.
module tea_dec_asmd
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = TEA_ROUNDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          start,
  input  logic [63:0]   data,
  input  logic [127:0]  key,
  output logic [63:0]   result,
  output logic          valid,
  output logic          rdy
);

`ifdef TEA_DEC_UNROLL2_EN
  localparam int unsigned Steps = ROUNDS / 2;
`else
  localparam int unsigned Steps = ROUNDS;
`endif
  localparam int unsigned    CntW    = $clog2(ROUNDS);
  localparam logic [CntW-1:0] CntLast = CntW'(Steps - 1);

  tea_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      v0_q, v0_d;
  logic [31:0]      v1_q, v1_d;
  logic [31:0]      sum_q, sum_d;
  logic [127:0]     key_q, key_d;
  logic [63:0]      result_q, result_d;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] r0_v0, r0_v1, r0_sum;
  logic [31:0] nxt_v0, nxt_v1, nxt_sum;

  assign {k0, k1, k2, k3} = key_q;

  tea_dec_round u_round0 (
    .v0_i  (v0_q),
    .v1_i  (v1_q),
    .sum_i (sum_q),
    .k0_i  (k0),
    .k1_i  (k1),
    .k2_i  (k2),
    .k3_i  (k3),
    .v0_o  (r0_v0),
    .v1_o  (r0_v1),
    .sum_o (r0_sum)
  );

`ifdef TEA_DEC_UNROLL2_EN
  logic [31:0] r1_v0, r1_v1, r1_sum;

  tea_dec_round u_round1 (
    .v0_i  (r0_v0),
    .v1_i  (r0_v1),
    .sum_i (r0_sum),
    .k0_i  (k0),
    .k1_i  (k1),
    .k2_i  (k2),
    .k3_i  (k3),
    .v0_o  (r1_v0),
    .v1_o  (r1_v1),
    .sum_o (r1_sum)
  );

  assign nxt_v0  = r1_v0;
  assign nxt_v1  = r1_v1;
  assign nxt_sum = r1_sum;
`else
  assign nxt_v0  = r0_v0;
  assign nxt_v1  = r0_v1;
  assign nxt_sum = r0_sum;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    sum_d    = sum_q;
    key_d    = key_q;
    result_d = result_q;
    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            v0_d    = data[63:32];
            v1_d    = data[31:0];
            key_d   = key;
            sum_d   = TEA_SUM_INIT;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          v0_d  = nxt_v0;
          v1_d  = nxt_v1;
          sum_d = nxt_sum;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            result_d = {nxt_v0, nxt_v1};
            state_d  = StDone;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      v0_q     <= '0;
      v1_q     <= '0;
      sum_q    <= '0;
      key_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      sum_q    <= sum_d;
      key_q    <= key_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign valid  = (state_q == StDone);
  assign rdy    = (state_q == StIdle);

endmodule
